mem_port_arbiter: RTL and testbench

//  Shares one 128-entry x 32-bit edge-strobed memory (trigRead/trigWrite model) between two requesters.

---
 rtl/mem_port_arbiter.sv | 148 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Two-port (fetch/data) arbiter driving an edge-strobed memory with setup/strobe/release pulses.
// Optional MEM_ARB_FIXED_PRIO_EN: data port always wins a tie instead of round-robin.
module mem_port_arbiter #(
    parameter int ADDR_W     = 7,
    parameter int DATA_W     = 32,
    parameter int SETUP_CYC  = 1,
    parameter int STROBE_CYC = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ack,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic [ADDR_W-1:0] mem_read_addr,
    output logic [ADDR_W-1:0] mem_write_addr,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              mem_trig_read,
    output logic              mem_trig_write,
    input  logic [DATA_W-1:0] mem_read_data,
    output logic              busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_STROBE,
        S_RELEASE,
        S_DONE
    } state_t;

    localparam int MAXC  = (SETUP_CYC > STROBE_CYC) ? SETUP_CYC : STROBE_CYC;
    localparam int CNT_W = (MAXC > 1) ? $clog2(MAXC) : 1;

    state_t              r_state;
    state_t              w_next;
    logic [CNT_W-1:0]    r_cnt;
    logic                w_cnt_last;
    logic                w_any_req;
    logic                w_grant_d;
    logic                r_sel_d;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_i_rdata;
    logic [DATA_W-1:0]   r_d_rdata;

    assign w_any_req = i_req | d_req;

`ifdef MEM_ARB_FIXED_PRIO_EN
    assign w_grant_d = d_req;
`else
    logic r_last_d;

    // Tie goes to whichever port was not granted last
    assign w_grant_d = d_req & (~i_req | ~r_last_d);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last_d <= 1'b1;
        end else if (r_state == S_IDLE && w_any_req) begin
            r_last_d <= w_grant_d;
        end
    end
`endif

    always_comb begin
        w_cnt_last = 1'b0;
        if (r_state == S_SETUP) begin
            w_cnt_last = (r_cnt == CNT_W'(SETUP_CYC - 1));
        end else if (r_state == S_STROBE) begin
            w_cnt_last = (r_cnt == CNT_W'(STROBE_CYC - 1));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (w_any_req) w_next = S_SETUP;
            S_SETUP:   if (w_cnt_last) w_next = S_STROBE;
            S_STROBE:  if (w_cnt_last) w_next = S_RELEASE;
            S_RELEASE: w_next = S_DONE;
            S_DONE:    w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if ((r_state == S_SETUP || r_state == S_STROBE) && !w_cnt_last) begin
            r_cnt <= r_cnt + 1'b1;
        end else begin
            r_cnt <= '0;
        end
    end

    // Request fields are frozen at grant and held through RELEASE
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sel_d <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (r_state == S_IDLE && w_any_req) begin
            r_sel_d <= w_grant_d;
            r_we    <= w_grant_d & d_we;
            r_addr  <= w_grant_d ? d_addr : i_addr;
            if (w_grant_d) r_wdata <= d_wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_i_rdata <= '0;
            r_d_rdata <= '0;
        end else if (r_state == S_RELEASE && !r_we) begin
            if (r_sel_d) r_d_rdata <= mem_read_data;
            else         r_i_rdata <= mem_read_data;
        end
    end

    assign mem_read_addr  = r_addr;
    assign mem_write_addr = r_addr;
    assign mem_write_data = r_wdata;
    assign mem_trig_read  = (r_state == S_STROBE) & ~r_we;
    assign mem_trig_write = (r_state == S_STROBE) & r_we;
    assign i_ack          = (r_state == S_DONE) & ~r_sel_d;
    assign d_ack          = (r_state == S_DONE) & r_sel_d;
    assign i_rdata        = r_i_rdata;
    assign d_rdata        = r_d_rdata;
    assign busy           = (r_state != S_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: table vectors, hand sequences, random rounds vs model.
// Honours MEM_ARB_FIXED_PRIO_EN in its expectations.
module tb_mem_port_arbiter;

`ifdef MEM_ARB_FIXED_PRIO_EN
    localparam bit          FIXED = 1'b1;
    localparam logic [31:0] EXP7  = 32'h11111111;
`else
    localparam bit          FIXED = 1'b0;
    localparam logic [31:0] EXP7  = 32'h22222222;
`endif
    localparam int LAT  = 4;
    localparam int LAT2 = 7;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_req, d_req, d_we, i_ack, d_ack, busy;
    logic [6:0]  i_addr, d_addr, m_raddr, m_waddr;
    logic [31:0] d_wdata, i_rdata, d_rdata, m_wdata, m_rdata;
    logic        m_tr, m_tw;

    logic        i2_req, d2_req, d2_we, i2_ack, d2_ack, busy2;
    logic [6:0]  i2_addr, d2_addr, m2_raddr, m2_waddr;
    logic [31:0] d2_wdata, i2_rdata, d2_rdata, m2_wdata, m2_rdata;
    logic        m2_tr, m2_tw;

    int checks = 0;
    int failures = 0;

    logic [31:0] mem_ref [128];
    logic        m_last_d;
    logic [31:0] m_ir, m_dr;

    logic        p_s1, p_s2;
    logic [6:0]  p_a1, p_a2;

    logic [31:0] mem  [128];
    logic        wr   [128];
    logic [31:0] mem2 [128];

    initial forever #5 clk = ~clk;

    mem_port_arbiter dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .mem_read_addr(m_raddr), .mem_write_addr(m_waddr),
        .mem_write_data(m_wdata), .mem_trig_read(m_tr),
        .mem_trig_write(m_tw), .mem_read_data(m_rdata), .busy(busy)
    );

    mem_port_arbiter #(.SETUP_CYC(3), .STROBE_CYC(2)) dut2 (
        .clk(clk), .reset(reset),
        .i_req(i2_req), .i_addr(i2_addr), .i_ack(i2_ack), .i_rdata(i2_rdata),
        .d_req(d2_req), .d_we(d2_we), .d_addr(d2_addr), .d_wdata(d2_wdata),
        .d_ack(d2_ack), .d_rdata(d2_rdata),
        .mem_read_addr(m2_raddr), .mem_write_addr(m2_waddr),
        .mem_write_data(m2_wdata), .mem_trig_read(m2_tr),
        .mem_trig_write(m2_tw), .mem_read_data(m2_rdata), .busy(busy2)
    );

    function automatic logic [31:0] pat(input logic [6:0] a);
        return {a, ~a, a, ~a, 4'hC};
    endfunction

    // Edge-strobed memories; unwritten words read back a fixed address pattern
    always @(posedge m_tw) begin
        mem[m_waddr] <= m_wdata;
        wr[m_waddr]  <= 1'b1;
    end
    always @(posedge m_tr)
        m_rdata <= (wr[m_raddr] === 1'b1) ? mem[m_raddr] : pat(m_raddr);
    always @(posedge m2_tw) mem2[m2_waddr] <= m2_wdata;
    always @(posedge m2_tr) m2_rdata <= mem2[m2_raddr];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        chk("strobe_mutex", 64'(m_tr & m_tw), 64'd0);
        chk("strobe_mutex2", 64'(m2_tr & m2_tw), 64'd0);
        if ((m_tr | m_tw) && p_s1) chk("addr_stable", 64'(m_raddr), 64'(p_a1));
        if ((m2_tr | m2_tw) && p_s2) chk("addr_stable2", 64'(m2_raddr), 64'(p_a2));
        if (m_tr | m_tw) chk("waddr_eq_raddr", 64'(m_waddr), 64'(m_raddr));
        p_s1 = m_tr | m_tw;
        p_a1 = m_raddr;
        p_s2 = m2_tr | m2_tw;
        p_a2 = m2_raddr;
    endtask

    // One arbitration round: raise the chosen reqs, serve them, drop each on its ack
    task automatic round(input bit ri, input bit rq, input logic [6:0] ia,
                         input bit we, input logic [6:0] da,
                         input logic [31:0] wd, input string tag,
                         output logic [31:0] got);
        bit pi, pd, ed, sr, sw;
        int n, ns, fs;
        pi = ri;
        pd = rq;
        got = '0;
        i_req = ri; i_addr = ia;
        d_req = rq; d_we = we; d_addr = da; d_wdata = wd;
        for (int k = 0; k < int'(ri) + int'(rq); k++) begin
            ed = (pi && pd) ? (FIXED ? 1'b1 : !m_last_d) : pd;
            n = 0; ns = 0; fs = 0; sr = 0; sw = 0;
            do begin
                tick();
                n++;
                if (m_tr | m_tw) begin
                    ns++;
                    if (fs == 0) fs = n;
                end
                sr |= m_tr;
                sw |= m_tw;
            end while (!i_ack && !d_ack && n < 40);
            chk({tag, " ack_port"}, {i_ack, d_ack}, ed ? 2'b01 : 2'b10);
            chk({tag, " latency"}, n, LAT + k);
            chk({tag, " strobe_len"}, ns, 1);
            chk({tag, " strobe_start"}, fs, 2 + k);
            chk({tag, " strobe_kind"}, {sr, sw}, (ed && we) ? 2'b01 : 2'b10);
            if (ed) begin
                if (we) mem_ref[da] = wd;
                else    m_dr = mem_ref[da];
                d_req = 0;
                pd = 0;
                got = d_rdata;
            end else begin
                m_ir = mem_ref[ia];
                i_req = 0;
                pi = 0;
                got = i_rdata;
            end
            chk({tag, " d_rdata"}, d_rdata, m_dr);
            chk({tag, " i_rdata"}, i_rdata, m_ir);
            m_last_d = ed;
        end
        tick();
        chk({tag, " idle"}, busy, 1'b0);
    endtask

    typedef struct {
        bit          ri;
        bit          rq;
        logic [6:0]  ia;
        bit          we;
        logic [6:0]  da;
        logic [31:0] wd;
        logic [31:0] exp;
    } vec_t;

    initial begin
        vec_t        tv [8];
        logic [31:0] got;
        int          n, ns, fs;
        bit          ed;
        logic [1:0]  pt;

        tv[0] = '{0, 1, 7'h00, 1, 7'h05, 32'hDEADBEEF, 32'h00000000};
        tv[1] = '{0, 1, 7'h00, 0, 7'h05, 32'h0,        32'hDEADBEEF};
        tv[2] = '{0, 1, 7'h00, 1, 7'h0A, 32'h12345678, 32'hDEADBEEF};
        tv[3] = '{1, 0, 7'h0A, 0, 7'h00, 32'h0,        32'h12345678};
        tv[4] = '{1, 0, 7'h05, 0, 7'h00, 32'h0,        32'hDEADBEEF};
        tv[5] = '{0, 1, 7'h00, 1, 7'h01, 32'h11111111, 32'hDEADBEEF};
        tv[6] = '{0, 1, 7'h00, 1, 7'h02, 32'h22222222, 32'hDEADBEEF};
        tv[7] = '{1, 1, 7'h01, 0, 7'h02, 32'h0,        EXP7};

        reset = 1;
        i_req = 0; i_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
        i2_req = 0; i2_addr = 0; d2_req = 0; d2_we = 0; d2_addr = 0; d2_wdata = 0;
        p_s1 = 0; p_s2 = 0; p_a1 = 0; p_a2 = 0;
        for (int i = 0; i < 128; i++) mem_ref[i] = pat(7'(i));
        m_last_d = 1; m_ir = 0; m_dr = 0;

        repeat (3) @(negedge clk);
        chk("rst_ctrl", {i_ack, d_ack, m_tr, m_tw, busy}, 5'b0);
        chk("rst_rdata", {i_rdata, d_rdata}, 64'd0);
        chk("rst_maddr", {m_raddr, m_waddr}, 14'd0);
        chk("rst_mwdata", m_wdata, 32'd0);
        chk("rst_busy2", busy2, 1'b0);
        reset = 0;
        tick();

        for (int v = 0; v < 8; v++) begin
            round(tv[v].ri, tv[v].rq, tv[v].ia, tv[v].we, tv[v].da, tv[v].wd,
                  $sformatf("vec%0d", v), got);
            chk($sformatf("vec%0d data", v), got, tv[v].exp);
        end

        // Both requests held continuously for six grants
        i_req = 1; i_addr = 7'h01; d_req = 1; d_we = 0; d_addr = 7'h02;
        for (int j = 0; j < 6; j++) begin
            ed = FIXED ? 1'b1 : !m_last_d;
            n = 0;
            do begin
                tick();
                n++;
            end while (!i_ack && !d_ack && n < 40);
            chk($sformatf("hold%0d port", j), {i_ack, d_ack}, ed ? 2'b01 : 2'b10);
            chk($sformatf("hold%0d lat", j), n, (j == 0) ? LAT : LAT + 1);
            if (ed) m_dr = mem_ref[7'h02];
            else    m_ir = mem_ref[7'h01];
            chk($sformatf("hold%0d data", j), ed ? d_rdata : i_rdata,
                ed ? m_dr : m_ir);
            m_last_d = ed;
            if (j == 5) begin
                i_req = 0;
                d_req = 0;
            end
        end
        tick();

        // Request dropped right after being sampled
        d_req = 1; d_we = 0; d_addr = 7'h05;
        tick();
        d_req = 0;
        n = 1;
        while (!d_ack && n < 40) begin
            tick();
            n++;
        end
        chk("drop lat", n, LAT);
        chk("drop data", d_rdata, 32'hDEADBEEF);
        m_dr = 32'hDEADBEEF;
        m_last_d = 1;
        tick();

        // Inputs changed after grant must not leak into the transaction
        d_req = 1; d_we = 1; d_addr = 7'h10; d_wdata = 32'hA5A50001;
        tick();
        d_addr = 7'h11; d_wdata = 32'hFFFF0000; d_we = 0;
        n = 1;
        while (!d_ack && n < 40) begin
            tick();
            n++;
        end
        chk("latch lat", n, LAT);
        chk("latch dr_hold", d_rdata, m_dr);
        d_req = 0;
        mem_ref[7'h10] = 32'hA5A50001;
        m_last_d = 1;
        tick();
        round(0, 1, 0, 0, 7'h10, 0, "latch_rd10", got);
        chk("latch rd10", got, 32'hA5A50001);
        round(0, 1, 0, 0, 7'h11, 0, "latch_rd11", got);

        for (int r = 0; r < 40; r++) begin
            pt = 2'($urandom_range(1, 3));
            round(pt[0], pt[1], 7'($urandom_range(0, 126)),
                  1'($urandom_range(0, 1)), 7'($urandom_range(0, 126)),
                  $urandom, $sformatf("rnd%0d", r), got);
        end

        // Reset while the write strobe is high
        d_req = 1; d_we = 1; d_addr = 7'h7F; d_wdata = 32'h0BADF00D;
        tick();
        tick();
        chk("rst_mid pre_strobe", m_tw, 1'b1);
        reset = 1;
        #1;
        chk("rst_mid strobes", {m_tr, m_tw}, 2'b00);
        chk("rst_mid busy", busy, 1'b0);
        chk("rst_mid ack", d_ack, 1'b0);
        d_req = 0;
        tick();
        chk("rst_mid ack2", {i_ack, d_ack}, 2'b00);
        reset = 0;
        m_last_d = 1; m_ir = 0; m_dr = 0;
        tick();
        chk("rst_mid idle", busy, 1'b0);
        round(0, 1, 0, 0, 7'h20, 0, "post_rst", got);

        // Longer setup/strobe instance
        d2_req = 1; d2_we = 1; d2_addr = 7'h03; d2_wdata = 32'hC0FFEE77;
        n = 0; ns = 0; fs = 0;
        do begin
            tick();
            n++;
            if (m2_tw) begin
                ns++;
                if (fs == 0) fs = n;
            end
        end while (!d2_ack && n < 60);
        chk("long_wr lat", n, LAT2);
        chk("long_wr strobe_len", ns, 2);
        chk("long_wr strobe_start", fs, 4);
        d2_req = 0;
        tick();
        d2_req = 1; d2_we = 0;
        n = 0; ns = 0;
        do begin
            tick();
            n++;
            if (m2_tr) ns++;
        end while (!d2_ack && n < 60);
        chk("long_rd lat", n, LAT2);
        chk("long_rd strobe_len", ns, 2);
        chk("long_rd data", d2_rdata, 32'hC0FFEE77);
        d2_req = 0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
